// File: rtl/results_streamer_if.sv
// results_streamer_if
//   Beat-level valid/ready bus from the results streamer to the CPU.
//   master : drives Bus_Data, Bus_Valid, Bus_Last; samples Bus_Ready
//   slave  : samples Bus_Data, Bus_Valid, Bus_Last; drives Bus_Ready
interface results_streamer_if #(
   parameter int BUS_WIDTH = 32
);
   logic [BUS_WIDTH-1:0] Bus_Data;
   logic                 Bus_Valid;
   logic                 Bus_Ready;
   logic                 Bus_Last;

   modport master (
      output Bus_Data,
      output Bus_Valid,
      output Bus_Last,
      input  Bus_Ready
   );

   modport slave (
      input  Bus_Data,
      input  Bus_Valid,
      input  Bus_Last,
      output Bus_Ready
   );
endinterface

// File: rtl/results_streamer.sv
// results_streamer
//   Reads the T/X result counts from result RAM, then streams T[t] followed
//   by X[t][0..NX-1] for every t to the CPU bus, each RAM word as
//   DATA_WIDTH/BUS_WIDTH beats (least-significant slice first). An optional
//   header sends the NT and NX words before the data.
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   Start           one-cycle request, honoured only when idle
//   Header_Enable   sampled with Start; send NT/NX header words
//   RAM_Data        read data, valid the cycle after the address
//   RAM_Address     read address
//   RAM_Read_Enable read strobe
//   bus             beat bus (Bus_Data/Bus_Valid/Bus_Ready/Bus_Last)
//   Busy            transfer in progress
//   Done            one-cycle completion pulse
//   Error           count out of range; sticky until the next accepted Start
module results_streamer #(
   parameter int ADDRESS_WIDTH = 13,
   parameter int DATA_WIDTH    = 64,
   parameter int BUS_WIDTH     = 32,
   parameter int COUNT_WIDTH   = 8,
   parameter int NUM_T_ADDR    = 1,
   parameter int NUM_X_ADDR    = 2,
   parameter int T_BASE_ADDR   = 3,
   parameter int X_BASE_ADDR   = 10
)(
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     Start,
   input  logic                     Header_Enable,
   input  logic [DATA_WIDTH-1:0]    RAM_Data,
   output logic [ADDRESS_WIDTH-1:0] RAM_Address,
   output logic                     RAM_Read_Enable,
   results_streamer_if.master       bus,
   output logic                     Busy,
   output logic                     Done,
   output logic                     Error
);

   localparam int BEATS = DATA_WIDTH / BUS_WIDTH;
   localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

   typedef enum logic [3:0] {
      IDLE, RD_NT, RD_NX, CHECK, HDR, FETCH, LOAD, SEND, FIN
   } state_t;

   state_t r_state, w_next;

   logic                     r_hdr_en;
   logic [COUNT_WIDTH-1:0]   r_nt, r_nx, r_t, r_x;
   logic                     r_nt_ovf;
   logic                     r_is_t;     // current word is a T word
   logic                     r_hdr_nx;   // header is on its second (NX) word
   logic [ADDRESS_WIDTH-1:0] r_xptr;     // running X address, replaces t*NX+x
   logic [DATA_WIDTH-1:0]    r_shift;
   logic [BCW-1:0]           r_beat;
   logic                     r_error;

   logic [COUNT_WIDTH-1:0]   w_nx;
   logic                     w_nx_ovf;
   logic                     w_sending, w_beat_done, w_word_end, w_last_word;

   assign w_nx        = RAM_Data[COUNT_WIDTH-1:0];
   assign w_nx_ovf    = |RAM_Data[DATA_WIDTH-1:COUNT_WIDTH];
   assign w_sending   = (r_state == HDR) || (r_state == SEND);
   assign w_beat_done = w_sending && bus.Bus_Ready;
   assign w_word_end  = w_beat_done && (r_beat == LAST_BEAT);
   assign w_last_word = !r_is_t && (r_x == r_nx - COUNT_WIDTH'(1)) &&
                        (r_t == r_nt - COUNT_WIDTH'(1));

   assign bus.Bus_Valid = w_sending;
   assign bus.Bus_Data  = w_sending ? r_shift[BUS_WIDTH-1:0] : '0;
   assign bus.Bus_Last  = (r_state == SEND) && w_last_word && (r_beat == LAST_BEAT);
   assign Error         = r_error;

   always_ff @(posedge CLK) begin
      if (RST) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next          = r_state;
      RAM_Address     = '0;
      RAM_Read_Enable = 1'b0;
      Busy            = (r_state != IDLE);
      Done            = 1'b0;
      case (r_state)
         IDLE:  if (Start) w_next = RD_NT;
         RD_NT: begin
            RAM_Address     = ADDRESS_WIDTH'(NUM_T_ADDR);
            RAM_Read_Enable = 1'b1;
            w_next          = RD_NX;
         end
         RD_NX: begin
            RAM_Address     = ADDRESS_WIDTH'(NUM_X_ADDR);
            RAM_Read_Enable = 1'b1;
            w_next          = CHECK;
         end
         CHECK: begin
            if (r_nt_ovf || w_nx_ovf)          w_next = FIN;
            else if (r_nt == '0 || w_nx == '0) w_next = FIN;
            else if (r_hdr_en)                 w_next = HDR;
            else                               w_next = FETCH;
         end
         HDR:   if (w_word_end && r_hdr_nx) w_next = FETCH;
         FETCH: begin
            RAM_Address     = r_is_t ? ADDRESS_WIDTH'(T_BASE_ADDR) + ADDRESS_WIDTH'(r_t)
                                     : r_xptr;
            RAM_Read_Enable = 1'b1;
            w_next          = LOAD;
         end
         LOAD:  w_next = SEND;
         SEND:  if (w_word_end) w_next = w_last_word ? FIN : FETCH;
         FIN: begin
            Done   = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_hdr_en <= 1'b0;
         r_nt     <= '0;
         r_nx     <= '0;
         r_t      <= '0;
         r_x      <= '0;
         r_nt_ovf <= 1'b0;
         r_is_t   <= 1'b0;
         r_hdr_nx <= 1'b0;
         r_xptr   <= '0;
         r_shift  <= '0;
         r_beat   <= '0;
         r_error  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (Start) begin
               r_hdr_en <= Header_Enable;
               r_error  <= 1'b0;
            end
            RD_NX: begin
               r_nt     <= RAM_Data[COUNT_WIDTH-1:0];
               r_nt_ovf <= |RAM_Data[DATA_WIDTH-1:COUNT_WIDTH];
            end
            CHECK: begin
               r_nx     <= w_nx;
               r_error  <= r_nt_ovf || w_nx_ovf;
               r_t      <= '0;
               r_x      <= '0;
               r_is_t   <= 1'b1;
               r_xptr   <= ADDRESS_WIDTH'(X_BASE_ADDR);
               r_beat   <= '0;
               r_hdr_nx <= 1'b0;
               r_shift  <= DATA_WIDTH'(r_nt);   // first header word, if used
            end
            HDR: if (w_beat_done) begin
               r_shift <= r_shift >> BUS_WIDTH;
               r_beat  <= r_beat + BCW'(1);
               if (w_word_end) begin
                  r_beat   <= '0;
                  r_hdr_nx <= 1'b1;
                  r_shift  <= DATA_WIDTH'(r_nx);
               end
            end
            LOAD: begin
               r_shift <= RAM_Data;
               r_beat  <= '0;
            end
            SEND: if (w_beat_done) begin
               r_shift <= r_shift >> BUS_WIDTH;
               r_beat  <= r_beat + BCW'(1);
               if (w_word_end) begin
                  r_beat <= '0;
                  if (r_is_t) begin
                     r_is_t <= 1'b0;
                  end else begin
                     r_xptr <= r_xptr + ADDRESS_WIDTH'(1);
                     // X wrap advances T and schedules the next T word
                     if (r_x == r_nx - COUNT_WIDTH'(1)) begin
                        r_x    <= '0;
                        r_t    <= r_t + COUNT_WIDTH'(1);
                        r_is_t <= 1'b1;
                     end else begin
                        r_x <= r_x + COUNT_WIDTH'(1);
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/results_streamer.md
Name: results_streamer

Overview:
- Parametrised successor to the solver's result-sending path.
- After a Start pulse it reads the result counts (number of T points, number of X values per T) from result RAM, then streams every T value, each followed by its X vector, to the CPU bus.
- Each RAM word goes out as DATA_WIDTH/BUS_WIDTH beats over a valid/ready handshake.
- An optional header mode sends the two counts first.

Parameters:
- ADDRESS_WIDTH, 13: RAM address width.
- DATA_WIDTH, 64: RAM word width; must be an integer multiple of BUS_WIDTH.
- BUS_WIDTH, 32: CPU bus width. BEATS = DATA_WIDTH/BUS_WIDTH, which may be 1.
- COUNT_WIDTH, 8: width of the T and X counters.
- NUM_T_ADDR, 1: RAM address of the T count.
- NUM_X_ADDR, 2: RAM address of the X-per-T count.
- T_BASE_ADDR, 3: address of T[0].
- X_BASE_ADDR, 10: address of X[0][0].

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-high.
- Start  in  1  one-cycle request to begin a transfer; ignored while Busy=1.
- Header_Enable  in  1  sampled with Start; 1 = send the NT word and the NX word before the data.
- RAM_Data  in  DATA_WIDTH  read data, valid the cycle after its address is presented.
- RAM_Address  out  ADDRESS_WIDTH  read address.
- RAM_Read_Enable  out  1  read strobe.
- Bus_Data  out  BUS_WIDTH  beat data.
- Bus_Valid  out  1  beat valid.
- Bus_Ready  in  1  CPU accepts the beat.
- Bus_Last  out  1  final beat of the transfer.
- Busy  out  1  transfer in progress.
- Done  out  1  one-cycle completion pulse.
- Error  out  1  count out of range; sticky until the next accepted Start.

Behaviour:
- Reset, synchronous: all outputs 0, FSM goes to IDLE, counters cleared. RST mid-transfer aborts immediately; there is no completion pulse.
- FSM states: IDLE, RD_NT, RD_NX, CHECK, HDR, FETCH, LOAD, SEND, FIN.
- IDLE:
  - On Start: latch Header_Enable, clear Error, set Busy=1, go to RD_NT.
- RD_NT: RAM_Address=NUM_T_ADDR, RAM_Read_Enable=1; go to RD_NX.
- RD_NX: RAM_Address=NUM_X_ADDR, RAM_Read_Enable=1; capture RAM_Data as NT; go to CHECK.
- CHECK (RAM_Data is NX):
  - If either count has nonzero bits above COUNT_WIDTH: Error=1, go to FIN with no beats sent.
  - Else if NT=0 or NX=0: go to FIN with no beats sent, Error=0.
  - Else go to HDR if the header was latched, otherwise go to FETCH.
- HDR: send NT, then NX, each as BEATS beats, zero-extended to DATA_WIDTH.
- Word order: T[0], X[0][0..NX-1], T[1], X[1][0..NX-1], …, ending with X[NT-1][NX-1].
- Addresses:
  - T[t] is at T_BASE_ADDR+t.
  - X[t][x] is at X_BASE_ADDR+t*NX+x.
  - The X address comes from an incrementing pointer; no multiplier.
  - Addresses wrap modulo 2^ADDRESS_WIDTH.
- FETCH: present the word address with RAM_Read_Enable=1.
- LOAD: capture RAM_Data into the beat shift register.
- SEND:
  - Bus_Valid=1; Bus_Data = current slice, least-significant slice first.
  - A beat transfers when Bus_Valid && Bus_Ready.
  - While Bus_Ready=0, Bus_Data and Bus_Last hold stable and Bus_Valid stays 1.
  - After the final beat of a word: go to FETCH, or to FIN if it was the last word.
- Counter rules: the X counter wraps from NX-1 to 0 and advances the T counter. A new T word is fetched after each X wrap.
- Bus_Last is asserted only on the final beat of X[NT-1][NX-1]; it is never asserted in the header.
- FIN: Done=1 for exactly one cycle, Busy=0 on the next cycle, go to IDLE.
- Start handling:
  - Start asserted in the same cycle as Done is ignored.
  - Start while Busy=1 is ignored.
- Timing, Bus_Ready held at 1 and no header:
  - Start is high in cycle 0; the first Bus_Valid is in cycle 6.
  - Each word costs BEATS+2 cycles.
- Bus_Valid is 0 in every state except HDR and SEND.

Test Plan:
- NT=2, NX=3, DATA_WIDTH=64, BUS_WIDTH=32, Ready=1, no header -> 16 beats in the order T0 lo/hi, X00, X01, X02, T1, X10–X12. Addresses are 3,10,11,12,4,13,14,15. Bus_Last on beat 16 only, Done one cycle later, first valid in cycle 6.
- Same stimulus with Header_Enable=1 -> 4 header beats (2,0,3,0) precede the data. Bus_Last is still only on the final data beat.
- Same stimulus with Bus_Ready toggling 1/0 each cycle -> Bus_Data held stable while stalled. The beat sequence is identical and there are no dropped or duplicated beats.
- NT=0, and separately NT=300 with COUNT_WIDTH=8 -> no Bus_Valid. Done pulses; Error=0 for the first case, Error=1 for the second. The next Start clears Error.
- DATA_WIDTH=BUS_WIDTH=32, NT=1, NX=1 -> exactly 2 beats. Start re-pulsed while Busy is ignored.
- RST asserted during the third beat -> all outputs are 0 on the next cycle, no Done pulse. A fresh Start then runs the full sequence correctly.
